// File: rtl/trap_eval_unit.sv
// Trap evaluation unit for tw/twi: registers the operand pair, evaluates the TO conditions
// and holds a trap request until acknowledged. Define TRAP_EVAL_COUNTER_EN for the trap counter.
module trap_eval_unit #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic [4:0]            to,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic                  flush,
    output logic                  trap_req,
    input  logic                  trap_ack,
    output logic [PC_WIDTH-1:0]   trap_pc,
    output logic [4:0]            trap_cause,
    output logic                  done,
    output logic [15:0]           trap_count
);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StReq
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] a_q, b_q;
    logic [4:0]            to_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic                  trap_req_q, trap_req_d;
    logic [PC_WIDTH-1:0]   trap_pc_q, trap_pc_d;
    logic [4:0]            trap_cause_q, trap_cause_d;
    logic                  done_q, done_d;
    logic                  capture;
    logic [4:0]            hits;
    logic [4:0]            cause;

    // Hit vector in TO bit order: lt, gt, eq, ltu, gtu.
    always_comb begin
        hits[4] = $signed(a_q) < $signed(b_q);
        hits[3] = $signed(a_q) > $signed(b_q);
        hits[2] = a_q == b_q;
        hits[1] = a_q < b_q;
        hits[0] = a_q > b_q;
        cause   = hits & to_q;
    end

    always_comb begin
        state_d      = state_q;
        trap_req_d   = trap_req_q;
        trap_pc_d    = trap_pc_q;
        trap_cause_d = trap_cause_q;
        done_d       = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_in && !flush) begin
                    capture = 1'b1;
                    state_d = StEval;
                end
            end
            StEval: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cause != 5'b0) begin
                    trap_req_d   = 1'b1;
                    trap_pc_d    = pc_q;
                    trap_cause_d = cause;
                    state_d      = StReq;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StReq: begin
                // The trap is older than any flush source, so only the ack releases it.
                if (trap_ack) begin
                    trap_req_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            trap_req_q   <= 1'b0;
            trap_pc_q    <= '0;
            trap_cause_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            trap_req_q   <= trap_req_d;
            trap_pc_q    <= trap_pc_d;
            trap_cause_q <= trap_cause_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            to_q <= '0;
            pc_q <= '0;
        end else if (capture) begin
            a_q  <= a;
            b_q  <= b;
            to_q <= to;
            pc_q <= pc_in;
        end
    end

`ifdef TRAP_EVAL_COUNTER_EN
    logic [15:0] trap_count_q;
    logic        count_inc;

    assign count_inc = (state_q == StReq) && trap_ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            trap_count_q <= '0;
        end else if (count_inc && (trap_count_q != 16'hFFFF)) begin
            trap_count_q <= trap_count_q + 16'd1;
        end
    end

    assign trap_count = trap_count_q;
`else
    assign trap_count = 16'h0000;
`endif

    // Gated by reset so decode sees no acceptance while reset is held.
    assign ready_out  = reset && (state_q == StIdle);
    assign trap_req   = trap_req_q;
    assign trap_pc    = trap_pc_q;
    assign trap_cause = trap_cause_q;
    assign done       = done_q;

endmodule

// File: tb/tb_trap_eval_unit.sv
// Self-checking bench for trap_eval_unit: transaction-level reference model, directed
// scenarios and randomized traffic, compared every cycle on the falling edge.
module tb_trap_eval_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  to;
    logic [31:0] pc_in;
    logic        flush;
    logic        trap_req;
    logic        trap_ack;
    logic [31:0] trap_pc;
    logic [4:0]  trap_cause;
    logic        done;
    logic [15:0] trap_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        chk_en = 1'b0;
    logic        skip_cnt = 1'b0;
    logic        preload = 1'b0;

    trap_eval_unit #(
        .WORD_WIDTH(32),
        .PC_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .a         (a),
        .b         (b),
        .to        (to),
        .pc_in     (pc_in),
        .flush     (flush),
        .trap_req  (trap_req),
        .trap_ack  (trap_ack),
        .trap_pc   (trap_pc),
        .trap_cause(trap_cause),
        .done      (done),
        .trap_count(trap_count)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_cause(input logic [31:0] x, input logic [31:0] y,
                                             input logic [4:0] t);
        longint sx, sy, ux, uy;
        logic [4:0] h;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        h  = {sx < sy, sx > sy, x == y, ux < uy, ux > uy};
        return h & t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding instruction, resolved one cycle after it is taken.
    logic        m_pend;
    logic [31:0] m_a, m_b, m_pc;
    logic [4:0]  m_to;
    logic        m_req;
    logic [31:0] m_tpc;
    logic [4:0]  m_cause;
    logic        m_done;
    logic [15:0] m_count;

    always @(posedge clk) begin
        if (!reset) begin
            m_pend  <= 1'b0;
            m_req   <= 1'b0;
            m_tpc   <= '0;
            m_cause <= '0;
            m_done  <= 1'b0;
            m_count <= '0;
        end else begin
            m_done <= 1'b0;
            if (preload) m_count <= 16'hFFFE;
            if (m_pend) begin
                m_pend <= 1'b0;
                if (!flush) begin
                    if (ref_cause(m_a, m_b, m_to) != 5'b0) begin
                        m_req   <= 1'b1;
                        m_tpc   <= m_pc;
                        m_cause <= ref_cause(m_a, m_b, m_to);
                    end else begin
                        m_done <= 1'b1;
                    end
                end
            end else if (m_req) begin
                if (trap_ack) begin
                    m_req <= 1'b0;
`ifdef TRAP_EVAL_COUNTER_EN
                    if (m_count != 16'hFFFF && !preload) m_count <= m_count + 16'd1;
`endif
                end
            end else if (valid_in && !flush) begin
                m_pend <= 1'b1;
                m_a    <= a;
                m_b    <= b;
                m_to   <= to;
                m_pc   <= pc_in;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_out", 32'(ready_out), 32'(reset && !m_pend && !m_req));
            check("trap_req", 32'(trap_req), 32'(m_req));
            check("trap_pc", trap_pc, m_tpc);
            check("trap_cause", 32'(trap_cause), 32'(m_cause));
            check("done", 32'(done), 32'(m_done));
            if (!skip_cnt) check("trap_count", 32'(trap_count), 32'(m_count));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic take_trap(input logic [31:0] pc);
        valid_in = 1'b1; a = 32'd1; b = 32'd2; to = 5'b11111; pc_in = pc;
        step();
        valid_in = 1'b0;
        step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
    endtask

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    int n_done;

    initial begin
        reset = 1'b0; valid_in = 1'b1; a = '0; b = '0; to = '0; pc_in = '0;
        flush = 1'b0; trap_ack = 1'b0;

        // Model pins, hand-computed.
        check("pin_boundary", 32'(ref_cause(32'h8000_0000, 32'h0, 5'b11111)), 32'h11);
        check("pin_neg_vs_one", 32'(ref_cause(32'hFFFF_FFFF, 32'h1, 5'b10001)), 32'h11);
        check("pin_no_hit", 32'(ref_cause(32'hFFFF_FFFF, 32'h1, 5'b01010)), 32'h0);
        check("pin_to_zero", 32'(ref_cause(32'h5, 32'h5, 5'b00000)), 32'h0);

        @(posedge clk);
        chk_en = 1'b1;
        step();
        step();
        check("ready_in_reset", 32'(ready_out), 32'h0);
        reset = 1'b1; valid_in = 1'b0;
        step();
        check("ready_after_reset", 32'(ready_out), 32'h1);

        // Equality trap held while ack stays low.
        valid_in = 1'b1; a = 32'd5; b = 32'd5; to = 5'b00100; pc_in = 32'h100;
        step();
        valid_in = 1'b0;
        step();
        for (int i = 0; i < 4; i++) step();
        check("eq_req", 32'(trap_req), 32'h1);
        check("eq_cause", 32'(trap_cause), 32'h04);
        check("eq_pc", trap_pc, 32'h100);
        check("eq_ready", 32'(ready_out), 32'h0);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("eq_released", 32'(trap_req), 32'h0);

        // Signed lt and unsigned gt at once, then the complementary TO that misses.
        valid_in = 1'b1; a = 32'hFFFF_FFFF; b = 32'd1; to = 5'b10001; pc_in = 32'h200;
        step();
        valid_in = 1'b0;
        step();
        check("mixed_cause", 32'(trap_cause), 32'h11);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        valid_in = 1'b1; to = 5'b01010; pc_in = 32'h204;
        step();
        valid_in = 1'b0;
        step();
        check("miss_done", 32'(done), 32'h1);
        check("miss_req", 32'(trap_req), 32'h0);
        step();
        check("miss_done_pulse", 32'(done), 32'h0);

        // Flush during evaluation kills the instruction.
        valid_in = 1'b1; a = 32'd1; b = 32'd2; to = 5'b11111; pc_in = 32'h300;
        step();
        valid_in = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_eval_req", 32'(trap_req), 32'h0);
        check("flush_eval_done", 32'(done), 32'h0);
        check("flush_eval_ready", 32'(ready_out), 32'h1);

        // Flush during a held request is ignored.
        valid_in = 1'b1; pc_in = 32'h304;
        step();
        valid_in = 1'b0;
        step();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) step();
        flush = 1'b0;
        check("flush_req_held", 32'(trap_req), 32'h1);
        check("flush_req_pc", trap_pc, 32'h304);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("flush_req_released", 32'(trap_req), 32'h0);

        // Counter saturation.
        take_trap(32'h400);
        take_trap(32'h404);
`ifdef TRAP_EVAL_COUNTER_EN
        skip_cnt = 1'b1; preload = 1'b1;
        force dut.trap_count_q = 16'hFFFE;
        step();
        release dut.trap_count_q;
        preload = 1'b0;
        step();
        skip_cnt = 1'b0;
        for (int i = 0; i < 3; i++) take_trap(32'h500 + 32'(i));
        check("count_saturated", 32'(trap_count), 32'hFFFF);
`else
        for (int i = 0; i < 3; i++) take_trap(32'h500 + 32'(i));
        check("count_tied_off", 32'(trap_count), 32'h0);
`endif

        // Back-to-back non-trapping issue: one accept and one done every two cycles.
        n_done = 0;
        valid_in = 1'b1; a = 32'd3; b = 32'd4; to = 5'b00000;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) n_done++;
        end
        valid_in = 1'b0;
        check("b2b_done_count", 32'(n_done), 32'd6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) != 0);
            valid_in = ($urandom_range(0, 2) != 0);
            a        = pick_word();
            b        = ($urandom_range(0, 3) == 0) ? a : pick_word();
            to       = 5'($urandom);
            pc_in    = $urandom & 32'hFFFF_FFFC;
            flush    = ($urandom_range(0, 7) == 0);
            trap_ack = ($urandom_range(0, 2) == 0);
            step();
        end
        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; trap_ack = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trap_eval_unit.md
Name: trap_eval_unit

Overview:
- Execute-side consumer of the decode stage's trap operand pair (a, b) for tw/twi instructions.
- Registers the operands and the 5-bit TO field, then evaluates the five signed/unsigned compare conditions.
- On a true condition, raises a held trap request with PC and cause toward the exception controller until acknowledged.
- Back-pressures decode while busy.

Parameters:
- WORD_WIDTH, 32, width of operands a and b (matches Word).
- PC_WIDTH, 32, width of the instruction address captured for the trap.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- valid_in  input  1  decode presents a trap instruction this cycle.
- ready_out  output  1  unit can accept; the transfer occurs when valid_in && ready_out.
- a  input  WORD_WIDTH  first compare operand (rA).
- b  input  WORD_WIDTH  second compare operand (rB or sign-extended SI).
- to  input  5  TO field: to[4]=lt signed, to[3]=gt signed, to[2]=eq, to[1]=lt unsigned, to[0]=gt unsigned.
- pc_in  input  PC_WIDTH  address of the trap instruction.
- flush  input  1  pipeline flush from a younger-priority redirect.
- trap_req  output  1  trap condition met; held until acknowledged.
- trap_ack  input  1  exception controller has taken the trap.
- trap_pc  output  PC_WIDTH  captured pc_in of the trapping instruction.
- trap_cause  output  5  per-condition hit vector (same bit order as to), masked by to.
- done  output  1  one-cycle pulse when an instruction retires without trapping.
- trap_count  output  16  taken-trap counter; see Optional Feature.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - trap_req=0, done=0, trap_pc=0, trap_cause=0, trap_count=0.
  - ready_out=1 in the cycle after reset is released.
  - Reset mid-operation abandons any pending request with no ack needed.
- States: IDLE, EVAL, REQ.
  - ready_out=1 only in IDLE; it is a combinational decode of the state.
- IDLE:
  - On valid_in && !flush, capture a, b, to, pc_in into internal registers and go to EVAL.
  - valid_in together with flush is not accepted; stay in IDLE.
- EVAL (one cycle after accept):
  - Compute hits: lt=$signed(a)<$signed(b), gt=$signed(a)>$signed(b), eq=(a==b), ltu=a<b, gtu=a>b.
  - cause = hits & to.
  - If flush: go to IDLE, no request, no done.
  - Else if cause!=0: register trap_cause=cause and trap_pc=pc, set trap_req=1, go to REQ.
  - Else: done=1 for exactly one cycle, go to IDLE.
- Latency: accept at edge N, trap_req or done visible after edge N+1.
  - Minimum initiation interval is 2 cycles when no trap occurs.
- REQ:
  - trap_req, trap_pc and trap_cause are held stable.
  - flush is ignored, because the trap is older than any flush source.
  - On trap_ack: trap_req=0 at the next edge, go to IDLE, trap_count increments.
  - trap_ack is ignored in IDLE and EVAL.
- to==0 never traps, and its cause is 0.
- to==5'b11111 always traps, since exactly one of lt/gt/eq holds.
- Boundary case a=32'h8000_0000, b=0: lt signed=1, gtu=1.

Optional Feature:
- Macro: TRAP_EVAL_COUNTER_EN.
- Defined: trap_count is a 16-bit counter incremented on each trap_ack accepted in REQ. It saturates at 16'hFFFF with no wrap and is cleared only by reset.
- Undefined: no counter flops; trap_count is tied to 0. The port list is unchanged.

Test Plan:
- Reset held low 3 cycles with valid_in=1 -> trap_req=0, done=0, trap_count=0, ready_out=0 during reset; ready_out=1 the cycle after release.
- a=5, b=5, to=5'b00100, pc_in=32'h100 -> trap_req=1 two edges after accept, trap_cause=5'b00100, trap_pc=32'h100. Hold trap_ack=0 for 4 cycles -> outputs stable, ready_out=0. Pulse trap_ack -> trap_req=0 next cycle.
- a=32'hFFFF_FFFF, b=1, to=5'b10001 -> trap_cause=5'b10001 (signed lt, unsigned gt). Then to=5'b01010 with the same operands -> no trap, single done pulse.
- Accept a=1, b=2, to=5'b11111, then assert flush in EVAL -> no trap_req, no done, back in IDLE. Repeat with flush during REQ -> trap_req stays 1 until trap_ack.
- With TRAP_EVAL_COUNTER_EN defined: force counter to 16'hFFFE via 2 preloaded traps plus backdoor, then take 3 more traps -> trap_count ends at 16'hFFFF. Without the macro, trap_count=0 throughout.
- Back-to-back valid_in=1 with non-trapping operands -> one accept every 2 cycles, done pulses every 2 cycles, ready_out alternates 1/0.
